// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//
// Unsigned sequential shift-and-add multiplier. A start accepted in IDLE or
// DONE latches the operands. The block then runs one add-and-shift iteration
// per clock for WIDTH clocks, and finally writes the 2*WIDTH-bit product and
// pulses done for one cycle. Each iteration uses a ripple-carry adder stage
// whose {carry, sum} result is shifted back into the {acc, mq} register pair.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; clears all state
//   start    request; accepted only in IDLE or DONE
//   a        multiplicand, sampled with an accepted start
//   b        multiplier, sampled with an accepted start
//   busy     high while an iteration sequence is in progress
//   done     one-cycle completion pulse
//   product  last completed product, held until the next completion or reset
//
// WIDTH must lie in the range 2..64.
// -----------------------------------------------------------------------------
module seq_shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;   // operands are latched at this edge
    logic            finish;   // this edge performs the final iteration

    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    count;

    // -------------------------------------------------------------------------
    // Ripple-carry adder stage, WIDTH+1 bits wide. acc[WIDTH] is always zero
    // when it reaches the adder, so the top sum bit is the carry-out of the
    // low WIDTH bits. That makes s the {carry, sum} result of
    // acc[WIDTH-1:0] + addend with carry-in 0.
    // -------------------------------------------------------------------------
    logic [WIDTH:0] addend;
    logic [WIDTH:0] carry;
    logic [WIDTH:0] s;

    assign addend   = mq[0] ? {1'b0, mcand} : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
        assign s[i] = acc[i] ^ addend[i] ^ carry[i];
        if (i < WIDTH) begin : g_carry
            assign carry[i+1] = (acc[i] & addend[i]) | (carry[i] & (acc[i] ^ addend[i]));
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of all the others.
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case
        // leaves a signal unassigned and infers a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start held through DONE restarts without an IDLE cycle.
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand latch, add-and-shift iteration, product capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            acc     <= '0;
            mq      <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            count <= '0;
        end else if (state == RUN) begin
            // {acc, mq} <= {1'b0, s, mq} >> 1. Shifting s, rather than
            // truncating it, keeps the adder carry-out in acc[WIDTH-1].
            acc   <= {1'b0, s[WIDTH:1]};
            mq    <= {s[0], mq[WIDTH-1:1]};
            count <= count + 1'b1;
            if (finish) begin
                // Equals {acc_next[WIDTH-1:0], mq_next} from the shift above.
                product <= {s, mq[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_shift_add_mult
//
// Self-checking bench for seq_shift_add_mult. It instantiates the block at
// WIDTH=32 and at WIDTH=8. Each accepted start pushes the expected product and
// the expected completion cycle onto a per-instance queue. A negedge monitor
// pops one entry for each done pulse and compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_seq_shift_add_mult;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        busy32;
    logic        done32;
    logic [63:0] product32;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    exp_t sb32[$];
    exp_t sb8[$];
    exp_t e32;
    exp_t e8;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic prev_done32 = 1'b0;
    logic prev_done8  = 1'b0;

    seq_shift_add_mult #(.WIDTH(32)) u_dut32 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start32),
        .a       (a32),
        .b       (b32),
        .busy    (busy32),
        .done    (done32),
        .product (product32)
    );

    seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: one queue entry per done pulse.
    always @(negedge clk) begin
        if (done32) begin
            check("done_width32", 64'(prev_done32), 64'd0);
            if (sb32.size() == 0) begin
                check("spurious_done32", 64'(done32), 64'd0);
            end else begin
                e32 = sb32.pop_front();
                check("product32", product32, e32.prod);
                check("done_cycle32", 64'(cyc), 64'(e32.due));
            end
        end
        if (done8) begin
            check("done_width8", 64'(prev_done8), 64'd0);
            if (sb8.size() == 0) begin
                check("spurious_done8", 64'(done8), 64'd0);
            end else begin
                e8 = sb8.pop_front();
                check("product8", 64'(product8), e8.prod);
                check("done_cycle8", 64'(cyc), 64'(e8.due));
            end
        end
        prev_done32 = done32;
        prev_done8  = done8;
    end

    task automatic push32(input logic [63:0] prod, input int due);
        exp_t e;
        e.prod = prod;
        e.due  = due;
        sb32.push_back(e);
    endtask

    // Called at a negedge while the 32-bit DUT is in IDLE or DONE.
    task automatic go32(input logic [31:0] x, input logic [31:0] y, input bit track);
        a32     = x;
        b32     = y;
        start32 = 1'b1;
        if (track) push32(64'(x) * 64'(y), cyc + 1 + 32);
        @(negedge clk);
        start32 = 1'b0;
    endtask

    task automatic go8(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        e.prod = 64'(16'(x) * 16'(y));
        e.due  = cyc + 1 + 8;
        sb8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_empty32(input int budget);
        int n = 0;
        while (sb32.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("timeout32", 64'(sb32.size()), 64'd0);
        sb32.delete();
    endtask

    task automatic wait_empty8(input int budget);
        int n = 0;
        while (sb8.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("timeout8", 64'(sb8.size()), 64'd0);
        sb8.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n   = 1'b0;
        start32 = 1'b0;
        start8  = 1'b0;
        a32     = '0;
        b32     = '0;
        a8      = '0;
        b8      = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_product32", product32, 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_product8", 64'(product8), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 3*5
        go32(32'd3, 32'd5, 1'b1);
        check("busy_after_start", 64'(busy32), 64'd1);
        wait_empty32(40);
        check("basic_product", product32, 64'h0000_0000_0000_000F);

        // Max operands: carry-out captured every iteration
        go32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_empty32(40);
        check("max_product", product32, 64'hFFFF_FFFE_0000_0001);

        // Zero multiplicand still runs full length
        go32(32'd0, 32'h1234_5678, 1'b1);
        wait_empty32(40);
        check("zero_product", product32, 64'd0);

        // Product holds the old value throughout the next RUN
        go32(32'h0001_0000, 32'h0001_0000, 1'b1);
        for (int i = 0; i < 31; i++) begin
            check("hold_product", product32, 64'd0);
            check("hold_busy", 64'(busy32), 64'd1);
            @(negedge clk);
        end
        wait_empty32(10);
        check("hold_final", product32, 64'h0000_0001_0000_0000);

        // start while RUN is ignored
        go32(32'd6, 32'd7, 1'b1);
        repeat (9) @(negedge clk);
        a32     = 32'd7;
        b32     = 32'd9;
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        check("busy_ignored", 64'(busy32), 64'd1);
        wait_empty32(40);
        check("ignored_product", product32, 64'h2A);
        repeat (5) @(negedge clk);

        // Back-to-back with start held high through DONE
        t       = cyc;
        a32     = 32'd2;
        b32     = 32'd3;
        start32 = 1'b1;
        push32(64'd6, t + 33);
        @(negedge clk);
        a32 = 32'd4;
        b32 = 32'd5;
        push32(64'd20, t + 66);
        while (cyc != t + 34) @(negedge clk);
        start32 = 1'b0;
        check("b2b_busy", 64'(busy32), 64'd1);
        wait_empty32(40);
        check("b2b_product", product32, 64'd20);

        // Asynchronous reset between edges in the middle of a RUN
        go32(32'h1234, 32'h5678, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", 64'(busy32), 64'd0);
        check("async_done", 64'(done32), 64'd0);
        check("async_product", product32, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_product", product32, 64'd0);
        check("post_rst_busy", 64'(busy32), 64'd0);

        // WIDTH=8 instance
        go8(8'hFF, 8'hFF);
        check("busy8_after_start", 64'(busy8), 64'd1);
        wait_empty8(20);
        check("max_product8", 64'(product8), 64'hFE01);
        go8(8'h00, 8'hA5);
        wait_empty8(20);
        check("zero_product8", 64'(product8), 64'd0);

        // Random operands on both instances, running concurrently
        for (int i = 0; i < 4; i++) begin
            go32(32'($urandom), 32'($urandom), 1'b1);
            go8(8'($urandom), 8'($urandom));
            wait_empty32(45);
            wait_empty8(45);
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Unsigned sequential multiplier built on a width-parameterised ripple-carry adder stage.
- Latches two WIDTH-bit operands, then performs one add-and-shift iteration per clock for WIDTH cycles.
- Each iteration drives the adder operands and consumes the adder's WIDTH+1-bit {carry, sum} result.
- Produces a 2*WIDTH-bit product with a start/busy/done handshake, for use by downstream datapath blocks.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 2..64.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk edge; accepted only in IDLE or DONE.
- a  input  WIDTH  multiplicand; sampled with an accepted start.
- b  input  WIDTH  multiplier; sampled with an accepted start.
- busy  output  1  high while an iteration sequence is in progress.
- done  output  1  one-cycle completion pulse.
- product  output  2*WIDTH  result register; holds the last completed product.

Behaviour:
- Reset: rst_n low asynchronously clears all state.
  - State goes to IDLE.
  - busy=0, done=0, product=0.
  - Internal acc, mq, mcand and count all go to 0.
  - Reset dominates any start.
- Internal registers:
  - mcand[WIDTH-1:0]: latched a.
  - acc[WIDTH:0]: upper partial product plus carry.
  - mq[WIDTH-1:0]: latched b, shifted right each iteration; low product bits shift in at its MSB.
  - count: ceil(log2(WIDTH+1)) bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge k: mcand<=a, mq<=b, acc<=0, count<=0, state<=RUN.
- RUN (busy=1):
  - Adder inputs: acc[WIDTH-1:0] and (mq[0] ? mcand : 0), carry-in 0.
  - The WIDTH+1-bit adder result s replaces acc; the shift then applies to {s, mq}.
  - Each edge: {acc, mq} <= {1'b0, s, mq} >> 1, i.e. acc<={1'b0, s[WIDTH:1]}, mq<={s[0], mq[WIDTH-1:1]}.
  - count<=count+1.
  - acc[WIDTH] is always 0 at the adder input. The adder carry-out is captured via the shift and is never lost.
  - When count==WIDTH-1 at an edge, that edge performs the final iteration and also:
    - product <= {acc_next[WIDTH-1:0], mq_next}
    - state <= DONE
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge: if start=1, accept new operands exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge k means busy=1 from after edge k until edge k+WIDTH. At edge k+WIDTH, product updates and done=1 for the cycle following edge k+WIDTH.
- Throughput: a new start is accepted every WIDTH+1 cycles when restarted in DONE.
- start while RUN: ignored, with no effect on operands, count or outputs.
- a and b may change freely after the accepting edge.
- product changes only at the completion edge or on reset. It is stable through RUN, DONE and IDLE.
- Operand value cases:
  - a=0 or b=0: full WIDTH iterations still run; product=0.
  - No early termination.
- Arithmetic is unsigned only; no overflow is possible (2*WIDTH bits is exact).
- Reset mid-RUN: sequence abandoned; product=0. No done pulse until a fresh start completes.

Test Plan:
- Basic, WIDTH=32: start with a=3, b=5 -> busy 32 cycles, done pulse 32 edges after the accepting edge, product=0x0000_0000_0000_000F.
- Max values: a=b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001. Checks adder carry-out capture every iteration.
- Zero and hold: a=0, b=0x1234_5678 -> product=0 after 32 cycles. Then a=0x0001_0000, b=0x0001_0000 -> product=0x0000_0001_0000_0000; product holds its old value throughout the second RUN until completion.
- start while busy: assert start with a=7, b=9 at cycle 10 of a RUN computing 6*7 -> ignored; product=42 (0x2A), single done pulse.
- Back-to-back: start held high continuously with a=2, b=3, then a=4, b=5 -> second operands accepted in the DONE cycle. done pulses are WIDTH+1 cycles apart, with products 6 then 20.
- Async reset mid-RUN and WIDTH=8 instance:
  - Drop rst_n between clock edges at cycle 5 of a RUN -> busy, done and product go to 0 immediately, with no done pulse afterwards.
  - WIDTH=8, a=b=0xFF -> product=0xFE01 after 8 cycles.
